// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end between execute stage and a word-wide data memory.
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready only while idle)
//   req_write, req_size, req_unsigned, req_addr, req_wdata
//                                    store flag, 00 byte/01 half/1x word, zero-extend, byte address, right-aligned data
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             extended load data, {out_of_range, misaligned}
//   mem_address, mem_wdata, mem_read, mem_write, mem_rdata
//                                    word-indexed data memory port
module mem_access_unit #(
    parameter int N = 32,
    parameter int M = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_rdata,
    output logic [1:0]   resp_err,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [N-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;
    state_t state, state_next;
    logic         wr;
    logic [1:0]   size;
    logic         uns;
    logic [N-1:0] addr;
    logic [N-1:0] wbuf;
    logic         misaligned;
    logic         out_of_range;
    logic [N-1:0] byte_shift;
    logic [N-1:0] half_shift;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;
    logic [N-1:0] load_val;
    logic [N-1:0] lane_mask;
    logic [N-1:0] lane_data;
    logic [N-1:0] merged;
    always_comb begin
        misaligned   = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
        out_of_range = {2'b00, req_addr[N-1:2]} >= N'(M);
        byte_shift   = mem_rdata >> {addr[1:0], 3'b000};
        half_shift   = mem_rdata >> {addr[1], 4'b0000};
        lane_byte    = byte_shift[7:0];
        lane_half    = half_shift[15:0];
        load_val     = size == 2'b00 ? {{(N-8){~uns & lane_byte[7]}}, lane_byte} :
                       size == 2'b01 ? {{(N-16){~uns & lane_half[15]}}, lane_half} : mem_rdata;
        // Stored sub-word is replicated across all lanes; the mask picks the target lane(s).
        lane_mask    = size == 2'b00 ? N'(32'h0000_00FF) << {addr[1:0], 3'b000} :
                                       N'(32'h0000_FFFF) << {addr[1], 4'b0000};
        lane_data    = size == 2'b00 ? {4{wbuf[7:0]}} : {2{wbuf[15:0]}};
        merged       = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req_valid)
                          state_next = (misaligned || out_of_range) ? RESP :
                                       !req_write ? LOAD :
                                       req_size[1] ? WRITE : RMW_READ;
            LOAD:     state_next = RESP;
            RMW_READ: state_next = WRITE;
            WRITE:    state_next = RESP;
            RESP:     if (resp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end
    always_comb begin
        req_ready   = state == IDLE;
        resp_valid  = state == RESP;
        mem_read    = state == LOAD || state == RMW_READ;
        mem_write   = state == WRITE;
        mem_address = (mem_read || mem_write) ? {2'b00, addr[N-1:2]} : '0;
        mem_wdata   = mem_write ? wbuf : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr         <= 1'b0;
            size       <= 2'b00;
            uns        <= 1'b0;
            addr       <= '0;
            wbuf       <= '0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr         <= req_write;
                    size       <= req_size;
                    uns        <= req_unsigned;
                    addr       <= req_addr;
                    wbuf       <= req_wdata;
                    resp_rdata <= '0;
                    resp_err   <= {out_of_range, misaligned};
                end
                LOAD:     resp_rdata <= load_val;
                RMW_READ: wbuf <= merged;
                default:  ;
            endcase
        end
endmodule
